fb_scanout: RTL and testbench

Framebuffer scanout engine: the read side of the video RAM, opposite the CPU write path through the 16390 bus switch. It generates 1bpp raster timing and fetches one byte per 8-pixel character slot from VRAM. It drives the bus-switch enables so the scanout and the 6502 never own the VRAM bus at the same time, and throttles the CPU through RDY.

---
 rtl/fb_scanout.sv | 142 ++++++++++++++
 tb/tb_fb_scanout.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: 1bpp framebuffer scanout engine.
// Generates raster timing, fetches one VRAM byte per 8-pixel slot, serialises it MSB-first,
// and drives the bus-switch enables so the scanout and the 6502 never share the VRAM bus.
// Optional build macro: FB_DOUBLE_SCAN_EN (each VRAM row is shown on two consecutive lines).
module fb_scanout #(
    parameter int unsigned H_BYTES     = 32,
    parameter int unsigned H_TOTAL     = 40,
    parameter int unsigned HSYNC_START = 34,
    parameter int unsigned HSYNC_LEN   = 4,
    parameter int unsigned V_ACTIVE    = 192,
    parameter int unsigned V_TOTAL     = 262,
    parameter int unsigned VSYNC_START = 224,
    parameter int unsigned VSYNC_LEN   = 3,
    parameter int unsigned ADDR_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        vram_data,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vid_oe_n,
    output logic              cpu_oe_n,
    output logic              rdy,
    output logic              pixel,
    output logic              hsync_n,
    output logic              vsync_n
);

    localparam int unsigned SW = $clog2(H_TOTAL);
    localparam int unsigned LW = $clog2(V_TOTAL);

    typedef struct packed {
        logic [LW-1:0] line;
        logic [SW-1:0] slot;
        logic [2:0]    phase;
    } pos_t;

    // Raster position one clock later, with frame wrap.
    function automatic pos_t advance(input pos_t p);
        pos_t n;
        n       = p;
        n.phase = p.phase + 3'd1;
        if (p.phase == 3'd7) begin
            if (p.slot == SW'(H_TOTAL - 1)) begin
                n.slot = '0;
                n.line = (p.line == LW'(V_TOTAL - 1)) ? '0 : p.line + LW'(1);
            end else begin
                n.slot = p.slot + SW'(1);
            end
        end
        return n;
    endfunction

    function automatic logic in_active_slot(input pos_t p);
        return (p.line < LW'(V_ACTIVE)) && (p.slot < SW'(H_BYTES));
    endfunction

    function automatic logic is_fetch(input pos_t p);
        return in_active_slot(p) && (p.phase <= 3'd3);
    endfunction

    // run_q is low only between reset and the first edge; pos_q is the current cycle's position.
    logic              run_q;
    pos_t              pos_q, pos_d, pos_dd;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [7:0]        latch_q;
    logic [7:0]        shift_q;
    logic              fetch_cur, fetch_nxt, fetch_nn;
    logic              line_end;

    // Next-position, line base and fetch-window decode.
    always_comb begin
        pos_d     = run_q ? advance(pos_q) : '0;
        pos_dd    = advance(pos_d);
        fetch_cur = run_q && is_fetch(pos_q);
        fetch_nxt = is_fetch(pos_d);
        fetch_nn  = is_fetch(pos_dd);
        line_end  = (pos_q.phase == 3'd7) && (pos_q.slot == SW'(H_TOTAL - 1));

        line_base_d = line_base_q;
        if (!run_q || (pos_d.line == '0)) begin
            line_base_d = '0;
        end else if (line_end && (pos_q.line < LW'(V_ACTIVE))) begin
`ifdef FB_DOUBLE_SCAN_EN
            // Only odd lines advance, so each row is scanned twice.
            if (pos_q.line[0]) begin
                line_base_d = line_base_q + ADDR_W'(H_BYTES);
            end
`else
            line_base_d = line_base_q + ADDR_W'(H_BYTES);
`endif
        end
    end

    // Counters, fetch path and registered outputs, all computed for the upcoming cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            pos_q       <= '0;
            line_base_q <= '0;
            latch_q     <= '0;
            shift_q     <= '0;
            vram_addr   <= '0;
            vid_oe_n    <= 1'b1;
            cpu_oe_n    <= 1'b1;
            rdy         <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
        end else begin
            run_q       <= 1'b1;
            pos_q       <= pos_d;
            line_base_q <= line_base_d;

            vid_oe_n <= ~fetch_nxt;
            // CPU side only when previous, current and next cycles are all non-fetch.
            cpu_oe_n <= fetch_cur | fetch_nxt | fetch_nn;
            rdy      <= ~(fetch_cur | fetch_nxt | fetch_nn);

            if (fetch_nxt) begin
                vram_addr <= line_base_d + ADDR_W'(pos_d.slot);
            end

            if (fetch_cur && (pos_q.phase == 3'd3)) begin
                latch_q <= vram_data;
            end

            // Load at the end of a fetched slot; zeros shift in so idle slots show black.
            if (run_q && (pos_q.phase == 3'd7) && in_active_slot(pos_q)) begin
                shift_q <= latch_q;
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end

            hsync_n <= ~((pos_d.slot >= SW'(HSYNC_START)) &&
                         (pos_d.slot < SW'(HSYNC_START + HSYNC_LEN)));
            vsync_n <= ~((pos_d.line >= LW'(VSYNC_START)) &&
                         (pos_d.line < LW'(VSYNC_START + VSYNC_LEN)));
        end
    end

    assign pixel = shift_q[7];

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout with an address/byte scoreboard.
module tb_fb_scanout;

    localparam int unsigned H_BYTES  = 32;
    localparam int unsigned H_TOTAL  = 40;
    localparam int unsigned V_ACTIVE = 192;
    localparam int unsigned V_TOTAL  = 262;
    localparam int unsigned ADDR_W   = 13;
    localparam int          LINE_CLK = H_TOTAL * 8;

    generate
        if (H_BYTES * V_ACTIVE > (1 << ADDR_W)) begin : g_size_bad
            initial $fatal(1, "FAIL size: framebuffer does not fit in ADDR_W");
        end
    endgenerate

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        vram_data;
    logic [ADDR_W-1:0] vram_addr;
    logic              vid_oe_n, cpu_oe_n, rdy, pixel, hsync_n, vsync_n;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [ADDR_W-1:0] addr_q[$];
    logic [7:0]        byte_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        cur_byte;

    always #5 clk = ~clk;

    // VRAM model: returns the low address byte, except a test pattern at address 0.
    assign vram_data = (vram_addr == '0) ? 8'hA5 : vram_addr[7:0];

    fb_scanout dut (
        .clk       (clk),
        .rst       (rst),
        .vram_data (vram_data),
        .vram_addr (vram_addr),
        .vid_oe_n  (vid_oe_n),
        .cpu_oe_n  (cpu_oe_n),
        .rdy       (rdy),
        .pixel     (pixel),
        .hsync_n   (hsync_n),
        .vsync_n   (vsync_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_fetch(input int t);
        int line, slot, phase;
        if (t < 0) return 1'b0;
        line  = (t / LINE_CLK) % V_TOTAL;
        slot  = (t % LINE_CLK) / 8;
        phase = t % 8;
        return (line < V_ACTIVE) && (slot < H_BYTES) && (phase <= 3);
    endfunction

    function automatic logic [ADDR_W-1:0] model_addr(input int line, input int slot);
        int row;
`ifdef FB_DOUBLE_SCAN_EN
        row = line / 2;
`else
        row = line;
`endif
        return ADDR_W'(row * H_BYTES + slot);
    endfunction

    function automatic logic [7:0] model_byte(input logic [ADDR_W-1:0] a);
        return (a == '0) ? 8'hA5 : a[7:0];
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_vid_oe_n"}, 32'(vid_oe_n), 32'd1);
        chk({tag, "_cpu_oe_n"}, 32'(cpu_oe_n), 32'd1);
        chk({tag, "_rdy"}, 32'(rdy), 32'd0);
        chk({tag, "_pixel"}, 32'(pixel), 32'd0);
        chk({tag, "_hsync_n"}, 32'(hsync_n), 32'd1);
        chk({tag, "_vsync_n"}, 32'(vsync_n), 32'd1);
        chk({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
    endtask

    // t counts cycles from the first edge after reset release (t=0 is line 0 slot 0 phase 0).
    task automatic check_cycle(input int t);
        int   line, slot, phase;
        logic ef, ecpu_low;
        line  = (t / LINE_CLK) % V_TOTAL;
        slot  = (t % LINE_CLK) / 8;
        phase = t % 8;
        ef    = model_fetch(t);
        ecpu_low = !model_fetch(t - 1) && !ef && !model_fetch(t + 1);

        if (slot == 0 && phase == 0 && line < V_ACTIVE) begin
            for (int s = 0; s < H_BYTES; s++) begin
                addr_q.push_back(model_addr(line, s));
                byte_q.push_back(model_byte(model_addr(line, s)));
            end
        end
        if (ef && phase == 0) begin
            if (addr_q.size() == 0) chk("addr_underflow", 32'd0, 32'd1);
            else exp_addr = addr_q.pop_front();
        end
        if (phase == 0) begin
            if (line < V_ACTIVE && slot >= 1 && slot <= H_BYTES) begin
                if (byte_q.size() == 0) begin
                    chk("byte_underflow", 32'd0, 32'd1);
                    cur_byte = 8'h00;
                end else begin
                    cur_byte = byte_q.pop_front();
                end
            end else begin
                cur_byte = 8'h00;
            end
        end

        chk("vram_addr", 32'(vram_addr), 32'(exp_addr));
        chk("pixel", 32'(pixel), 32'(cur_byte[7 - phase]));
        chk("vid_oe_n", 32'(vid_oe_n), 32'(!ef));
        chk("cpu_oe_n", 32'(cpu_oe_n), 32'(!ecpu_low));
        chk("rdy", 32'(rdy), 32'(ecpu_low));
        chk("bus_excl", 32'(vid_oe_n | cpu_oe_n), 32'd1);
        chk("hsync_n", 32'(hsync_n), 32'(!(slot >= 34 && slot < 38)));
        chk("vsync_n", 32'(vsync_n), 32'(!(line >= 224 && line < 227)));
    endtask

    task automatic start_run();
        addr_q.delete();
        byte_q.delete();
        exp_addr = '0;
        cur_byte = 8'h00;
    endtask

    initial begin
        // Power-on reset.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset("por");

        // Short run into the middle of line 0.
        rst = 1'b0;
        start_run();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            check_cycle(t);
        end

        // Mid-line asynchronous reset held for 3 clocks.
        rst = 1'b1;
        #1;
        check_reset("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset("rst_hold");
        end

        // Full frame plus the first lines of the next frame.
        rst = 1'b0;
        start_run();
        for (int t = 0; t < V_TOTAL * LINE_CLK + 2 * LINE_CLK; t++) begin
            @(negedge clk);
            check_cycle(t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
